// File: rtl/uart_fifo.sv
// uart_fifo: WISHBONE-slave UART with TX/RX FIFOs, programmable divisor, sticky line errors
// and a maskable level interrupt. Define UART_PARITY_EN to build in the parity bit and LCR.
module uart_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 2,
  parameter logic [15:0] DIV_RESET = 16'd2604
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [4:2]  ADD_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  input  logic        RxD,
  output logic        TxD,
  output logic        IRQ_O
);

  localparam int unsigned Depth   = 1 << FIFO_AW;
  localparam int unsigned BitCntW = 3;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // Bus decode
  logic wr, rd, lsr_rd;
  assign wr     = STB_I & WE_I;
  assign rd     = STB_I & ~WE_I;
  assign lsr_rd = rd && (ADD_I == 3'd2);
  assign ACK_O  = STB_I;

  logic unused_dat_hi;
  assign unused_dat_hi = ^DAT_I[31:16];

  // Control registers and sticky flags
  logic [2:0]  ier_q;
  logic [15:0] div_q;
  logic        oe_q, fe_q, pe_q;
  logic        oe_set, fe_set, pe_set;
  logic [15:0] div_eff, div_half;

  assign div_eff  = (div_q < 16'd4) ? 16'd4 : div_q;
  assign div_half = div_eff >> 1;

`ifdef UART_PARITY_EN
  logic [1:0] lcr_q;
  logic       par_en, par_odd;
  assign par_en  = (lcr_q == 2'b01) || (lcr_q == 2'b10);
  assign par_odd = (lcr_q == 2'b10);
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ier_q <= '0;
      div_q <= DIV_RESET;
      oe_q  <= 1'b0;
      fe_q  <= 1'b0;
      pe_q  <= 1'b0;
`ifdef UART_PARITY_EN
      lcr_q <= '0;
`endif
    end else begin
      if (wr && ADD_I == 3'd1) ier_q <= DAT_I[2:0];
      if (wr && ADD_I == 3'd4) div_q <= DAT_I[15:0];
`ifdef UART_PARITY_EN
      if (wr && ADD_I == 3'd3) lcr_q <= DAT_I[1:0];
`endif
      // A new error in the same cycle as an LSR read survives the clear
      oe_q <= (oe_q & ~lsr_rd) | oe_set;
      fe_q <= (fe_q & ~lsr_rd) | fe_set;
      pe_q <= (pe_q & ~lsr_rd) | pe_set;
    end
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem_q [Depth];
  logic [FIFO_AW:0]     tx_wptr_q, tx_rptr_q;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  state_e               tx_state_q;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[FIFO_AW] != tx_rptr_q[FIFO_AW]) &&
                    (tx_wptr_q[FIFO_AW-1:0] == tx_rptr_q[FIFO_AW-1:0]);
  assign tx_push  = wr && (ADD_I == 3'd0) && !tx_full;
  assign tx_pop   = (tx_state_q == StIdle) && !tx_empty;
  assign tx_head  = tx_mem_q[tx_rptr_q[FIFO_AW-1:0]];

  always_ff @(posedge CLK_I) begin
    if (tx_push) tx_mem_q[tx_wptr_q[FIFO_AW-1:0]] <= DAT_I[DATA_BITS-1:0];
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // TX shifter
  logic [15:0]          tx_cnt_q;
  logic [BitCntW-1:0]   tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 txd_q;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      case (tx_state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (tx_pop) begin
            tx_shift_q <= tx_head;
`ifdef UART_PARITY_EN
            tx_par_q   <= (^tx_head) ^ par_odd;
`endif
            tx_cnt_q   <= div_eff - 16'd1;
            txd_q      <= 1'b0;
            tx_state_q <= StStart;
          end
        end
        StStart: begin
          if (tx_cnt_q != 16'd0) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end else begin
            tx_cnt_q   <= div_eff - 16'd1;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
            tx_state_q <= StData;
          end
        end
        StData: begin
          if (tx_cnt_q != 16'd0) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end else begin
            tx_cnt_q <= div_eff - 16'd1;
            if (tx_bit_q == LastBit) begin
`ifdef UART_PARITY_EN
              if (par_en) begin
                txd_q      <= tx_par_q;
                tx_state_q <= StParity;
              end else begin
                txd_q      <= 1'b1;
                tx_state_q <= StStop;
              end
`else
              txd_q      <= 1'b1;
              tx_state_q <= StStop;
`endif
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (tx_cnt_q != 16'd0) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end else begin
            tx_cnt_q   <= div_eff - 16'd1;
            txd_q      <= 1'b1;
            tx_state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (tx_cnt_q != 16'd0) tx_cnt_q <= tx_cnt_q - 16'd1;
          else                   tx_state_q <= StIdle;
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  assign TxD = txd_q;

  // RX synchroniser; rxs_prev_q is for start-edge detection
  logic rx_s1_q, rx_s2_q, rxs_prev_q, rxs;
  assign rxs = rx_s2_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_s1_q    <= RxD;
      rx_s2_q    <= rx_s1_q;
      rxs_prev_q <= rx_s2_q;
    end
  end

  // RX FIFO
  logic [DATA_BITS-1:0] rx_mem_q [Depth];
  logic [FIFO_AW:0]     rx_wptr_q, rx_rptr_q;
  logic                 rx_empty, rx_full, rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_shift_q;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[FIFO_AW] != rx_rptr_q[FIFO_AW]) &&
                    (rx_wptr_q[FIFO_AW-1:0] == rx_rptr_q[FIFO_AW-1:0]);
  assign rx_pop   = rd && (ADD_I == 3'd0) && !rx_empty;

  always_ff @(posedge CLK_I) begin
    if (rx_push) rx_mem_q[rx_wptr_q[FIFO_AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  // RX deserialiser
  state_e             rx_state_q;
  logic [15:0]        rx_cnt_q;
  logic [BitCntW-1:0] rx_bit_q;
  logic               rx_fire, rx_good, par_bad;
`ifdef UART_PARITY_EN
  logic               rx_par_q;
  assign par_bad = par_en && (rx_par_q != ((^rx_shift_q) ^ par_odd));
`else
  assign par_bad = 1'b0;
`endif

  // The stop-bit sample decides the fate of the whole character
  assign rx_fire = (rx_state_q == StStop) && (rx_cnt_q == 16'd0);
  assign rx_good = rx_fire && rxs && !par_bad;
  assign fe_set  = rx_fire && !rxs;
  assign pe_set  = rx_fire && rxs && par_bad;
  assign oe_set  = rx_good && rx_full;
  assign rx_push = rx_good && !rx_full;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
    end else begin
      case (rx_state_q)
        StIdle: begin
          if (rxs_prev_q && !rxs) begin
            rx_cnt_q   <= div_half - 16'd1;
            rx_state_q <= StStart;
          end
        end
        StStart: begin
          if (rx_cnt_q != 16'd0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else if (rxs) begin
            rx_state_q <= StIdle;
          end else begin
            rx_cnt_q   <= div_eff - 16'd1;
            rx_bit_q   <= '0;
            rx_state_q <= StData;
          end
        end
        StData: begin
          if (rx_cnt_q != 16'd0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else begin
            rx_cnt_q   <= div_eff - 16'd1;
            rx_shift_q <= {rxs, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == LastBit) begin
`ifdef UART_PARITY_EN
              rx_state_q <= par_en ? StParity : StStop;
`else
              rx_state_q <= StStop;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (rx_cnt_q != 16'd0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else begin
            rx_cnt_q   <= div_eff - 16'd1;
            rx_par_q   <= rxs;
            rx_state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (rx_cnt_q != 16'd0) rx_cnt_q <= rx_cnt_q - 16'd1;
          else                   rx_state_q <= StIdle;
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  // Status, read mux and interrupt
  logic       tx_idle;
  logic [6:0] lsr;
  assign tx_idle = tx_empty && (tx_state_q == StIdle);
  assign lsr     = {tx_empty, tx_idle, tx_full, pe_q, fe_q, oe_q, !rx_empty};

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      3'd0: if (!rx_empty) DAT_O[DATA_BITS-1:0] = rx_mem_q[rx_rptr_q[FIFO_AW-1:0]];
      3'd1: DAT_O[2:0] = ier_q;
      3'd2: DAT_O[6:0] = lsr;
`ifdef UART_PARITY_EN
      3'd3: DAT_O[1:0] = lcr_q;
`endif
      3'd4: DAT_O[15:0] = div_q;
      default: DAT_O = '0;
    endcase
  end

  assign IRQ_O = (ier_q[0] & !rx_empty) | (ier_q[1] & tx_empty) |
                 (ier_q[2] & (oe_q | fe_q | pe_q));

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: randomized self-checking bench for uart_fifo; expected values come from
// per-cycle frame bit lists and queue models of the FIFOs.
module tb_uart_fifo;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  add;
  logic [31:0] dat_i;
  wire  [31:0] dat_o;
  logic        stb, we;
  wire         ack, txd, irq;
  logic        rxd_drv, loop_en;
  wire         rxd = loop_en ? txd : rxd_drv;

  int total = 0;
  int bad   = 0;
  int par_mode = 0;  // 0 none, 1 even, 2 odd
  bit exp_q[$];
  logic [7:0] txb_q[$];

  always #5 clk = ~clk;

  uart_fifo dut (
    .CLK_I(clk), .RST_I(rst), .ADD_I(add), .DAT_I(dat_i), .DAT_O(dat_o),
    .STB_I(stb), .WE_I(we), .ACK_O(ack), .RxD(rxd), .TxD(txd), .IRQ_O(irq)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); stb = 1'b1; we = 1'b1; add = a; dat_i = d;
    @(posedge clk); #1; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); stb = 1'b1; we = 1'b0; add = a;
    #1 d = dat_o;
    @(posedge clk); #1; stb = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [7:0] b, input int p);
    repeat (p) exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) repeat (p) exp_q.push_back(b[i]);
    if (par_mode == 1) repeat (p) exp_q.push_back(^b);
    if (par_mode == 2) repeat (p) exp_q.push_back(~^b);
    repeat (p) exp_q.push_back(1'b1);
  endtask

  // Drive one 16-cycle-per-bit frame on rxd_drv; par < 0 means no parity bit
  task automatic send_frame(input logic [7:0] b, input logic stop, input int par);
    @(negedge clk);
    rxd_drv = 1'b0; repeat (16) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxd_drv = b[i]; repeat (16) @(negedge clk);
    end
    if (par >= 0) begin
      rxd_drv = par[0]; repeat (16) @(negedge clk);
    end
    rxd_drv = stop; repeat (16) @(negedge clk);
    rxd_drv = 1'b1; repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1; stb = 1'b0; we = 1'b0; add = '0; dat_i = '0;
    rxd_drv = 1'b1; loop_en = 1'b0;
    wait_cycles(3);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    @(negedge clk); stb = 1'b1; #1;
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL ack_follows_stb: got %b want 1", ack); end
    stb = 1'b0; #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL ack_idle: got %b want 0", ack); end
    bus_read(3'd2, d);
    total++; if (d !== 32'h60) begin bad++; $display("FAIL reset_lsr: got %h want 60", d); end
    bus_read(3'd4, d);
    total++; if (d !== 32'd2604) begin bad++; $display("FAIL reset_div: got %0d want 2604", d); end
    bus_read(3'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ier: got %h want 0", d); end
    bus_read(3'd0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", d); end
    bus_read(3'd5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped: got %h want 0", d); end
    bus_write(3'd1, 32'h2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_txe: got %b want 1", irq); end
    bus_write(3'd1, 32'h0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", irq); end
  endtask

  // Writes txb_q back-to-back and checks TxD every cycle against the frame model
  task automatic test_tx_wave(input int p);
    logic [31:0] d;
    int n;
    n = txb_q.size();
    exp_q.delete();
    exp_q.push_back(1'b1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) exp_q.push_back(1'b1);
      push_frame(txb_q[i], p);
    end
    for (int i = 0; i < n; i++) bus_write(3'd0, {24'h0, txb_q[i]});
    for (int c = n - 1; c < exp_q.size(); c++) begin
      @(negedge clk);
      total++;
      if (txd !== exp_q[c]) begin
        bad++; $display("FAIL tx_wave p=%0d cycle %0d: got %b want %b", p, c, txd, exp_q[c]);
      end
    end
    bus_read(3'd2, d);
    total++; if (d !== 32'h60) begin bad++; $display("FAIL tx_idle_after_stop: got %h want 60", d); end
    txb_q.delete();
  endtask

  task automatic test_tx_frames;
    logic [31:0] d;
    bus_write(3'd4, 32'd16);
    txb_q.push_back(8'hA5);
    test_tx_wave(16);
    txb_q.push_back(8'($urandom));
    txb_q.push_back(8'($urandom));
    test_tx_wave(16);
    bus_write(3'd4, 32'd2);
    bus_read(3'd4, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL div_raw: got %0d want 2", d); end
    txb_q.push_back(8'($urandom));
    test_tx_wave(4);
  endtask

  task automatic test_loopback_full;
    logic [31:0] d;
    logic [7:0]  x;
    logic [7:0]  mq[$];
    int          w;
    bus_write(3'd4, 32'd16);
    bus_write(3'd1, 32'd1);
    loop_en = 1'b1;
    x = 8'($urandom);
    bus_write(3'd0, {24'h0, x});
    wait_cycles(3);
    for (int v = 1; v <= 5; v++) begin
      bus_write(3'd0, v);
      if (mq.size() < 4) mq.push_back(8'(v));
    end
    bus_read(3'd2, d);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL tx_full_lsr: got %h want 10", d); end
    w = 0;
    while (irq !== 1'b1 && w < 600) begin @(negedge clk); w++; end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq_timeout: got %b want 1", irq); end
    bus_read(3'd0, d);
    total++; if (d !== {24'h0, x}) begin bad++; $display("FAIL loop_first: got %h want %h", d, x); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_after_pop: got %b want 0", irq); end
    wait_cycles(900);
    bus_read(3'd2, d);
    total++; if (d !== 32'h61) begin bad++; $display("FAIL loop_lsr: got %h want 61", d); end
    while (mq.size() > 0) begin
      bus_read(3'd0, d);
      total++;
      if (d !== {24'h0, mq[0]}) begin
        bad++; $display("FAIL loop_data: got %h want %h", d, mq[0]);
      end
      void'(mq.pop_front());
    end
    bus_read(3'd0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL read_empty: got %h want 0", d); end
    bus_write(3'd1, 32'd0);
    loop_en = 1'b0;
  endtask

  task automatic test_random_loopback;
    logic [31:0] d;
    logic [7:0]  mq[$];
    logic [7:0]  b;
    int          dv, n;
    loop_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      dv = $urandom_range(8, 24);
      n  = $urandom_range(1, 4);
      bus_write(3'd4, dv);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        mq.push_back(b);
        bus_write(3'd0, {24'h0, b});
      end
      wait_cycles(n * 11 * dv + 3 * dv + 50);
      bus_read(3'd2, d);
      total++; if (d !== 32'h61) begin bad++; $display("FAIL rnd_lsr: got %h want 61", d); end
      while (mq.size() > 0) begin
        bus_read(3'd0, d);
        total++;
        if (d !== {24'h0, mq[0]}) begin
          bad++; $display("FAIL rnd_data div=%0d: got %h want %h", dv, d, mq[0]);
        end
        void'(mq.pop_front());
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    logic [7:0]  mq[$];
    logic [7:0]  b;
    logic        oe;
    oe = 1'b0;
    bus_write(3'd4, 32'd16);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (mq.size() < 4) mq.push_back(b);
      else oe = 1'b1;
      send_frame(b, 1'b1, (par_mode == 0) ? -1 : ((par_mode == 1) ? int'(^b) : int'(~^b)));
    end
    bus_read(3'd2, d);
    total++;
    if (d !== {25'h0, 5'b11000, oe, 1'b1}) begin
      bad++; $display("FAIL overrun_lsr: got %h want %h", d, {25'h0, 5'b11000, oe, 1'b1});
    end
    bus_read(3'd2, d);
    total++; if (d !== 32'h61) begin bad++; $display("FAIL oe_cleared: got %h want 61", d); end
    while (mq.size() > 0) begin
      bus_read(3'd0, d);
      total++;
      if (d !== {24'h0, mq[0]}) begin bad++; $display("FAIL ovr_data: got %h want %h", d, mq[0]); end
      void'(mq.pop_front());
    end
  endtask

  task automatic test_frame_error;
    logic [31:0] d;
    bus_write(3'd1, 32'h4);
    send_frame(8'($urandom), 1'b0, -1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL fe_irq: got %b want 1", irq); end
    bus_read(3'd2, d);
    total++; if (d !== 32'h64) begin bad++; $display("FAIL fe_lsr: got %h want 64", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL fe_irq_clear: got %b want 0", irq); end
    @(negedge clk); rxd_drv = 1'b0;
    wait_cycles(4);
    rxd_drv = 1'b1;
    wait_cycles(60);
    bus_read(3'd2, d);
    total++; if (d !== 32'h60) begin bad++; $display("FAIL glitch_lsr: got %h want 60", d); end
    bus_read(3'd0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_data: got %h want 0", d); end
    bus_write(3'd1, 32'h0);
  endtask

  task automatic test_parity;
    logic [31:0] d;
    logic [7:0]  b;
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, d);
`ifdef UART_PARITY_EN
    total++; if (d !== 32'h1) begin bad++; $display("FAIL lcr_rd: got %h want 1", d); end
    par_mode = 1;
    bus_write(3'd1, 32'h4);
    send_frame(8'h07, 1'b1, 0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pe_irq: got %b want 1", irq); end
    bus_read(3'd2, d);
    total++; if (d !== 32'h68) begin bad++; $display("FAIL pe_lsr: got %h want 68", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL pe_irq_clear: got %b want 0", irq); end
    b = 8'($urandom);
    send_frame(b, 1'b1, int'(^b));
    bus_read(3'd0, d);
    total++; if (d !== {24'h0, b}) begin bad++; $display("FAIL par_good: got %h want %h", d, b); end
    txb_q.push_back(8'($urandom));
    test_tx_wave(16);
    bus_write(3'd1, 32'h0);
    bus_write(3'd3, 32'h0);
    par_mode = 0;
`else
    total++; if (d !== 32'h0) begin bad++; $display("FAIL lcr_disabled: got %h want 0", d); end
`endif
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    bus_write(3'd4, 32'd16);
    bus_write(3'd0, 32'h00);
    wait_cycles(30);
    #2 rst = 1'b1;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL async_reset_txd: got %b want 1", txd); end
    @(negedge clk); rst = 1'b0;
    bus_read(3'd2, d);
    total++; if (d !== 32'h60) begin bad++; $display("FAIL midframe_lsr: got %h want 60", d); end
    bus_read(3'd4, d);
    total++; if (d !== 32'd2604) begin bad++; $display("FAIL midframe_div: got %0d want 2604", d); end
    wait_cycles(40);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL midframe_idle: got %b want 1", txd); end
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx_frames();
    test_loopback_full();
    test_random_loopback();
    test_overrun();
    test_frame_error();
    test_parity();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
